// File: rtl/data_mem.sv
// data_mem: single-port word RAM with a registered, read-first read port (1-cycle latency, no backpressure).
// Optional DATA_MEM_CLEAR_EN: zero-fill sweep after every reset, busy high while it runs.
module data_mem #(
   parameter int ABITS = 32,
   parameter int DBITS = 32,
   parameter int DEPTH = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             we,
   input  logic [ABITS-1:0] addr,
   input  logic [DBITS-1:0] din,
   output logic [DBITS-1:0] dout,
   output logic             busy
);
   localparam int AW = $clog2(DEPTH);

   logic [DBITS-1:0] mem [DEPTH];
   logic [AW-1:0]    idx;
   logic             wr_en;
   logic [AW-1:0]    wr_idx;
   logic [DBITS-1:0] wr_dat;
   logic             rd_en;

   // Upper address bits alias onto the same words and are deliberately dropped.
   assign idx = addr[AW-1:0];
   generate
      if (AW < ABITS) begin : g_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^addr[ABITS-1:AW];
      end
   endgenerate

`ifdef DATA_MEM_CLEAR_EN
   logic [AW-1:0] sweep_ptr;
   logic          sweeping;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sweeping  <= 1'b1;
         sweep_ptr <= '0;
      end else if (sweeping) begin
         sweep_ptr <= sweep_ptr + 1'b1;
         if (sweep_ptr == AW'(DEPTH - 1))
            sweeping <= 1'b0;
      end
   end

   // The sweep owns the write port; user traffic is dropped until it finishes.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = idx;
      wr_dat = din;
      rd_en  = 1'b0;
      if (rst_n) begin
         if (sweeping) begin
            wr_en  = 1'b1;
            wr_idx = sweep_ptr;
            wr_dat = '0;
         end else begin
            wr_en = we;
            rd_en = en;
         end
      end
   end

   assign busy = sweeping;
`else
   always_comb begin
      wr_en  = rst_n & we;
      wr_idx = idx;
      wr_dat = din;
      rd_en  = rst_n & en;
   end

   assign busy = 1'b0;
`endif

   // No reset on the array: contents survive reset unless the sweep clears them.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= wr_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         dout <= '0;
      else if (rd_en)
         dout <= mem[idx];
   end
endmodule

// File: tb/tb_data_mem.sv
// Randomized and directed bench for data_mem against a word-array reference model.
module tb_data_mem;
   localparam int ABITS = 32;
   localparam int DBITS = 32;
   localparam int DEPTH = 1024;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             we;
   logic [ABITS-1:0] addr;
   logic [DBITS-1:0] din;
   logic [DBITS-1:0] dout;
   logic             busy;

   int passed = 0;
   int total  = 0;

   logic [DBITS-1:0] m_mem [DEPTH];
   logic [DBITS-1:0] m_dout;
   int               m_sweep;

   data_mem #(.ABITS(ABITS), .DBITS(DBITS), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .we   (we),
      .addr (addr),
      .din  (din),
      .dout (dout),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: one call per rising edge, applying the access rules directly.
   function automatic void model_edge(input logic r, input logic e, input logic w,
                                      input logic [31:0] a, input logic [31:0] d);
      int i;
      i = int'(a % DEPTH);
      if (!r) begin
         m_dout = '0;
`ifdef DATA_MEM_CLEAR_EN
         m_sweep = DEPTH;
`endif
      end else if (m_sweep > 0) begin
         m_mem[DEPTH - m_sweep] = '0;
         m_sweep--;
      end else begin
         if (e) m_dout = m_mem[i];
         if (w) m_mem[i] = d;
      end
   endfunction

   task automatic drive(input logic r, input logic e, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      rst_n = r; en = e; we = w; addr = a; din = d;
      @(posedge clk);
      #1;
      model_edge(r, e, w, a, d);
   endtask

   // Idles while busy, bounded so a stuck busy cannot hang the run.
   task automatic wait_ready(output int n);
      n = 0;
      while (busy === 1'b1 && n < 2 * DEPTH) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      drive(1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
      drive(1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
      total++;
      if (dout !== 32'h0) $display("FAIL reset_dout: got %h want 00000000", dout);
      else passed++;
      total++;
      if (busy !== (m_sweep > 0)) $display("FAIL reset_busy: got %b want %b", busy, m_sweep > 0);
      else passed++;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      total++;
      if (dout !== 32'h0) $display("FAIL reset_read0: got %h want 00000000", dout);
      else passed++;
      wait_ready(n);
      total++;
      if (busy !== 1'b0) $display("FAIL reset_ready: busy got %b want 0 after %0d cycles", busy, n);
      else passed++;
   endtask

   task automatic test_write_only();
      drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_F123);
      total++;
      if (dout !== 32'h0) $display("FAIL wo_hold: got %h want 00000000", dout);
      else passed++;
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      total++;
      if (dout !== 32'h0000_F123) $display("FAIL wo_read: got %h want 0000f123", dout);
      else passed++;
   endtask

   task automatic test_collision();
      drive(1'b1, 1'b0, 1'b1, 32'd5, 32'h0000_000A);
      drive(1'b1, 1'b1, 1'b1, 32'd5, 32'h0000_000B);
      total++;
      if (dout !== 32'h0000_000A) $display("FAIL coll_old: got %h want 0000000a", dout);
      else passed++;
      drive(1'b1, 1'b1, 1'b0, 32'd5, 32'h0);
      total++;
      if (dout !== 32'h0000_000B) $display("FAIL coll_new: got %h want 0000000b", dout);
      else passed++;
   endtask

   task automatic test_alias_hold();
      drive(1'b1, 1'b0, 1'b1, DEPTH, 32'h1234_5678);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      total++;
      if (dout !== 32'h1234_5678) $display("FAIL alias_read: got %h want 12345678", dout);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 1'b0, $urandom, $urandom);
         total++;
         if (dout !== 32'h1234_5678) $display("FAIL hold_%0d: got %h want 12345678", k, dout);
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [31:0] exp;
      drive(1'b1, 1'b0, 1'b1, 32'd3, 32'hDEAD_BEEF);
      drive(1'b1, 1'b1, 1'b0, 32'd3, 32'h0);
      total++;
      if (dout !== 32'hDEAD_BEEF) $display("FAIL mid_pre: got %h want deadbeef", dout);
      else passed++;
      drive(1'b0, 1'b1, 1'b1, 32'd3, 32'h1);
      total++;
      if (dout !== 32'h0) $display("FAIL mid_rst: got %h want 00000000", dout);
      else passed++;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_ready(n);
      drive(1'b1, 1'b1, 1'b0, 32'd3, 32'h0);
`ifdef DATA_MEM_CLEAR_EN
      exp = 32'h0;
`else
      exp = 32'hDEAD_BEEF;
`endif
      total++;
      if (dout !== exp) $display("FAIL mid_after: got %h want %h", dout, exp);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic r, e, w;
      logic [31:0] a;
      for (int k = 0; k < 400; k++) begin
         r = ($urandom_range(0, 99) != 0);
         e = $urandom_range(0, 1);
         w = $urandom_range(0, 1);
         a = ($urandom & ~32'(DEPTH - 1)) | 32'($urandom_range(0, 15));
         drive(r, e, w, a, $urandom);
         total++;
         if (dout !== m_dout || busy !== (m_sweep > 0))
            $display("FAIL rand_%0d: dout %h busy %b want dout %h busy %b",
                     k, dout, busy, m_dout, m_sweep > 0);
         else passed++;
      end
      for (int k = 0; k < 2 * DEPTH && m_sweep > 0; k++) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

`ifdef DATA_MEM_CLEAR_EN
   task automatic test_sweep();
      int n;
      int probe [4] = '{7, 100, 1023, 0};
      drive(1'b1, 1'b0, 1'b1, 32'd7,    32'hAAAA_0007);
      drive(1'b1, 1'b0, 1'b1, 32'd100,  32'hAAAA_0100);
      drive(1'b1, 1'b0, 1'b1, 32'd1023, 32'hAAAA_1023);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      n = 0;
      while (busy === 1'b1 && n < 2 * DEPTH) begin
         drive(1'b1, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFF);
         n++;
      end
      total++;
      if (n !== DEPTH) $display("FAIL sweep_len: got %0d cycles want %0d", n, DEPTH);
      else passed++;
      total++;
      if (dout !== 32'h0) $display("FAIL sweep_dout: got %h want 00000000", dout);
      else passed++;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b1, 1'b0, probe[k], 32'h0);
         total++;
         if (dout !== 32'h0) $display("FAIL sweep_probe_%0d: got %h want 00000000", probe[k], dout);
         else passed++;
      end
   endtask
`endif

   initial begin
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      m_dout  = '0;
      m_sweep = 0;
      rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = '0; din = '0;
      test_reset();
      test_write_only();
      test_collision();
      test_alias_hold();
      test_reset_mid();
      test_back_to_back();
`ifdef DATA_MEM_CLEAR_EN
      test_sweep();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
